// File: rtl/can_pkg.sv
// Shared CAN receive-path definitions: destuffer states, the stuff run length,
// and the Gray/parity helpers used by the FD stuff-count check.
package can_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DYN   = 2'd1,
        FIXED = 2'd2,
        ERROR = 2'd3
    } destuff_state_t;

    localparam int STUFF_LEN_DEFAULT = 5;

    function automatic logic [2:0] to_gray3(input logic [2:0] value);
        return value ^ (value >> 1);
    endfunction

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic parity3(input logic [2:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/bit_destuffer.sv
// Removes dynamic CAN stuff bits, checks CAN FD fixed stuff bits and keeps the
// Gray-coded stuff count that the FD stuff-count field is compared against.
module bit_destuffer
    import can_pkg::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       samplePoint,
    input  logic       canRX,
    input  logic       BS_onoff,
    input  logic       fixedStuff,
    output logic       isStuff,
    output logic       isError,
    output logic       bitOut,
    output logic       bitValid,
    output logic [2:0] stuffCount,
    output logic [2:0] stuffCntGray,
    output logic       stuffCntParity
);

    localparam logic [2:0] STUFF_RUN = 3'(STUFF_LEN);

    destuff_state_t state;
    logic           lastBit;
    logic [2:0]     runLen;
    logic [2:0]     fixPos;

    logic       same_bit;
    logic [2:0] run_next;
    logic [2:0] fix_pos_cur;

    assign same_bit    = (canRX == lastBit);
    assign run_next    = same_bit ? ((runLen == 3'd7) ? 3'd7 : runLen + 3'd1) : 3'd1;
    // Entering the fixed region from anywhere restarts the position at the stuff slot.
    assign fix_pos_cur = (state == FIXED) ? fixPos : 3'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lastBit    <= 1'b1;
            runLen     <= 3'd0;
            fixPos     <= 3'd0;
            isStuff    <= 1'b0;
            isError    <= 1'b0;
            bitOut     <= 1'b1;
            bitValid   <= 1'b0;
            stuffCount <= 3'd0;
        end else begin
            bitValid <= 1'b0;
            if (samplePoint) begin
                bitOut  <= canRX;
                lastBit <= canRX;
                runLen  <= run_next;
                fixPos  <= 3'd0;
                isStuff <= 1'b0;
                isError <= 1'b0;

                if (state == ERROR && (BS_onoff || fixedStuff)) begin
                    isError <= 1'b1;
                end else if (fixedStuff) begin
                    state  <= FIXED;
                    fixPos <= (fix_pos_cur == 3'd4) ? 3'd0 : fix_pos_cur + 3'd1;
                    if (fix_pos_cur == 3'd0) begin
                        if (same_bit) begin
                            isError <= 1'b1;
                            state   <= ERROR;
                        end else begin
                            isStuff <= 1'b1;
                        end
                    end else begin
                        bitValid <= 1'b1;
                    end
                end else if (BS_onoff) begin
                    state <= DYN;
                    if (runLen == STUFF_RUN) begin
                        if (same_bit) begin
                            isError <= 1'b1;
                            state   <= ERROR;
                        end else begin
                            isStuff    <= 1'b1;
                            stuffCount <= stuffCount + 3'd1;
                        end
                    end else begin
                        bitValid <= 1'b1;
                    end
                end else begin
                    state      <= IDLE;
                    bitValid   <= 1'b1;
                    stuffCount <= 3'd0;
                end
            end
        end
    end

    assign stuffCntGray   = to_gray3(stuffCount);
    assign stuffCntParity = parity3(stuffCntGray);

endmodule

// File: tb/tb_bit_destuffer.sv
// Directed bench for bit_destuffer: dynamic stuffing, stuff errors, count wrap,
// FD fixed stuff bits and mid-frame reset, all against hand-computed values.
module tb_bit_destuffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       samplePoint;
    logic       canRX;
    logic       BS_onoff;
    logic       fixedStuff;
    logic       isStuff;
    logic       isError;
    logic       bitOut;
    logic       bitValid;
    logic [2:0] stuffCount;
    logic [2:0] stuffCntGray;
    logic       stuffCntParity;

    int checks = 0;
    int errors = 0;

    // Gray codes and their even parity bits for counts 0..7.
    logic [2:0] grayTable   [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    logic       parityTable [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    bit_destuffer dut (
        .clk            (clk),
        .rst            (rst),
        .samplePoint    (samplePoint),
        .canRX          (canRX),
        .BS_onoff       (BS_onoff),
        .fixedStuff     (fixedStuff),
        .isStuff        (isStuff),
        .isError        (isError),
        .bitOut         (bitOut),
        .bitValid       (bitValid),
        .stuffCount     (stuffCount),
        .stuffCntGray   (stuffCntGray),
        .stuffCntParity (stuffCntParity)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One bit time: strobe samplePoint for a single clk, outputs are settled afterwards.
    task automatic applyStimulus(input logic b, input logic bs, input logic fs);
        @(negedge clk);
        canRX       = b;
        BS_onoff    = bs;
        fixedStuff  = fs;
        samplePoint = 1'b1;
        @(posedge clk);
        #1;
        samplePoint = 1'b0;
    endtask

    task automatic checkBit(input string tag, input logic stuff, input logic valid, input logic err);
        checkOutput({tag, ".isStuff"}, 8'(isStuff), 8'(stuff));
        checkOutput({tag, ".bitValid"}, 8'(bitValid), 8'(valid));
        checkOutput({tag, ".isError"}, 8'(isError), 8'(err));
    endtask

    task automatic checkCount(input string tag, input int cnt);
        checkOutput({tag, ".stuffCount"}, 8'(stuffCount), 8'(cnt));
        checkOutput({tag, ".stuffCntGray"}, 8'(stuffCntGray), 8'(grayTable[cnt]));
        checkOutput({tag, ".stuffCntParity"}, 8'(stuffCntParity), 8'(parityTable[cnt]));
    endtask

    task automatic checkResetValues(input string tag);
        checkBit(tag, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, ".bitOut"}, 8'(bitOut), 8'h01);
        checkCount(tag, 0);
    endtask

    task automatic idleBits(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic v;
        rst         = 1'b1;
        samplePoint = 1'b0;
        canRX       = 1'b1;
        BS_onoff    = 1'b0;
        fixedStuff  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        @(negedge clk);
        rst = 1'b0;

        // Bus idle: every bit is a data bit.
        idleBits(3);
        checkBit("idle", 1'b0, 1'b1, 1'b0);
        checkOutput("idle.bitOut", 8'(bitOut), 8'h01);

        // SOF plus four dominant bits, then the recessive stuff bit.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkBit($sformatf("dyn0.b%0d", i), 1'b0, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkBit("dyn0.stuff", 1'b1, 1'b0, 1'b0);
        checkOutput("dyn0.bitOut", 8'(bitOut), 8'h01);
        checkCount("dyn0.stuff", 1);
        @(posedge clk);
        #1;
        checkOutput("hold.bitValid", 8'(bitValid), 8'h00);
        checkOutput("hold.isStuff", 8'(isStuff), 8'h01);

        // Stuff bit starts a recessive run; the sixth consecutive 1 is a stuff error.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            checkBit($sformatf("err.b%0d", i), 1'b0, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkBit("err.sixth", 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkBit("err.hold0", 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkBit("err.hold1", 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("err.exit", 8'(isError), 8'h00);

        // Eight stuff conditions in one frame: count wraps back to 0.
        idleBits(2);
        checkCount("wrap.start", 0);
        v = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < ((k == 0) ? 5 : 4); i++) applyStimulus(v, 1'b1, 1'b0);
            applyStimulus(~v, 1'b1, 1'b0);
            checkBit($sformatf("wrap.s%0d", k), 1'b1, 1'b0, 1'b0);
            checkCount($sformatf("wrap.s%0d", k), (k + 1) % 8);
            v = ~v;
        end
        idleBits(1);
        checkCount("wrap.idle", 0);

        // Dynamic stuff (count 1), frame ends recessive, then the fixed-stuff region.
        idleBits(2);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkCount("fix.pre", 1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkBit("fix.off0", 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkBit($sformatf("fix.off%0d", i), 1'b0, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkBit("fix.off5", 1'b1, 1'b0, 1'b0);
        checkCount("fix.frozen", 1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkBit("fix.off9", 1'b0, 1'b1, 1'b0);
        // Fixed stuff slot equal to the previous bit.
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("fix.bad.isError", 8'(isError), 8'h01);
        checkOutput("fix.bad.bitValid", 8'(bitValid), 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkBit("fix.bad.hold", 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("fix.bad.exit", 8'(isError), 8'h00);

        // Mid-frame reset with runLen 4 and stuffCount 3.
        idleBits(2);
        v = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < ((k == 0) ? 5 : 4); i++) applyStimulus(v, 1'b1, 1'b0);
            applyStimulus(~v, 1'b1, 1'b0);
            v = ~v;
        end
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        checkCount("rst.pre", 3);
        @(negedge clk);
        rst         = 1'b1;
        samplePoint = 1'b1;
        canRX       = 1'b0;
        BS_onoff    = 1'b1;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        samplePoint = 1'b0;
        checkResetValues("rst.mid");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkBit($sformatf("rst.sof%0d", i), 1'b0, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkBit("rst.nostuff", 1'b0, 1'b1, 1'b0);
        checkCount("rst.post", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
